local_controller_multichannel: RTL
==================================

# local_controller_multichannel

Parametrised successor to the single-stream local controller with one prefetch port. It holds one circular sample buffer and streams it to N_CH independent delay channels. Each channel has its own delay and destination address. A separate prefetch engine with backpressure returns an arbitrary, possibly wrapping, address window. The block sits between the global controller, which supplies configuration, and the NoC injection ports, which receive the packets.

## Interface
- N_SAMPLE, 1024, sample buffer depth; must be a power of 2
- DATAWIDTH, 16, width of the I and Q halves; a sample is 2*DATAWIDTH wide
- ADDR_VEC_WIDTH, 8, width of the destination address vector
- SAMPLE_ADDR_WIDTH, 10, log2(N_SAMPLE)
- N_CH, 2, number of streaming channels; CH_W = max(1, clog2(N_CH))
- PACKET_WIDTH, 2*DATAWIDTH+ADDR_VEC_WIDTH, packet layout is {dest, sample}, with dest in the MSBs

Ports:
- CLK  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  sample write strobe
- wr_addr  in  SAMPLE_ADDR_WIDTH  write address
- wr_data  in  2*DATAWIDTH  write sample
- cfg_valid  in  1  channel configuration strobe; always accepted
- cfg_ch  in  CH_W  target channel
- cfg_delay  in  SAMPLE_ADDR_WIDTH  start read address
- cfg_dest  in  ADDR_VEC_WIDTH  destination for the channel
- run  in  1  pulse; moves every ARMED channel to RUN
- stop  in  1  pulse; moves every channel to IDLE
- pkt_out  out  N_CH*PACKET_WIDTH  channel c occupies slice [c*PACKET_WIDTH +: PACKET_WIDTH]
- pkt_valid  out  N_CH  per-channel packet valid; no backpressure
- boundary_next  out  N_CH  high together with the packet read from address N_SAMPLE-1
- pf_valid  in  1  prefetch request valid
- pf_ready  out  1  prefetch engine idle; request accepted when pf_valid && pf_ready
- pf_start  in  SAMPLE_ADDR_WIDTH  first address of the window (inclusive)
- pf_stop  in  SAMPLE_ADDR_WIDTH  last address of the window (inclusive)
- pf_dest  in  ADDR_VEC_WIDTH  prefetch destination
- pf_pkt_out  out  PACKET_WIDTH  prefetch packet
- pf_pkt_valid  out  1  prefetch packet valid
- pf_pkt_ready  in  1  downstream accept
- pf_done  out  1  one-cycle pulse on acceptance of the last window packet

## Operation
- **Buffer:** N_SAMPLE x 2*DATAWIDTH register array. It is not reset. A write lands at the edge where wr_en=1. A read of the same address in the same cycle returns the old data (read-before-write).
- **Channel state:** each channel has state IDLE/ARMED/RUN, a pointer ptr, and a dest register.
  - cfg_valid to an IDLE or ARMED channel loads ptr=cfg_delay and dest=cfg_dest, and moves the channel to ARMED.
  - cfg_valid to a RUN channel reloads ptr and dest. The channel stays in RUN, and the next packet comes from the new delay.
  - run: ARMED → RUN. If cfg_valid and run occur in the same cycle on an IDLE/ARMED channel, the channel enters RUN with the new values.
  - stop: every channel → IDLE. stop overrides run and cfg in the same cycle; cfg values are still loaded, but the state ends IDLE.
- **Channel read:** in each RUN cycle the output register loads {dest, mem[ptr]}, pkt_valid[c] is set to 1, and ptr increments modulo N_SAMPLE (N_SAMPLE-1 wraps to 0). In a non-RUN cycle, pkt_valid[c] is set to 0 and pkt_out holds its last value.
- **Prefetch FSM, PF_IDLE:** pf_ready=1. On accept, latch start, stop and dest; set remaining = ((stop-start) mod N_SAMPLE)+1; go to PF_RUN. start==stop gives one packet. stop<start wraps through address 0.
- **Prefetch FSM, PF_RUN:** pf_ready=0. When an address is still pending and (!pf_pkt_valid || pf_pkt_ready), load pf_pkt_out={dest, mem[pf_ptr]}, set pf_pkt_valid=1, and advance pf_ptr with wrap.
  - While valid && !ready, pf_pkt_out and pf_pkt_valid hold stable.
  - On acceptance of the last packet: pf_done=1, pf_pkt_valid drops unless a new packet is loaded, and the FSM returns to PF_IDLE.
- Prefetch and channel reads are independent; there is no arbitration or stall between them.

## Timing
- **Reset (reset_n low, asynchronous):**
  - All outputs are 0 except pf_ready=1.
  - Channels go to IDLE with ptr=0 and dest=0; the prefetch FSM goes to PF_IDLE.
  - Reset mid-stream or mid-window drops everything in flight immediately, with no pf_done.
- **Channel latency:** if run is sampled at edge t, the first packet, {dest, mem[delay]}, is valid after edge t+1. After that, one packet per cycle back-to-back.
- **Stop latency:** stop sampled at edge t means pkt_valid is low after edge t+1; the packet loaded at edge t is still presented.
- **Retarget latency:** cfg to a RUN channel at edge t means the packet after edge t+1 uses the new delay and dest.
- **Prefetch latency:** request accepted at edge t means the first packet is valid after edge t+1. Sustained throughput is 1 packet/cycle while pf_pkt_ready=1.
- pf_done is asserted in the cycle after the edge that accepted the last packet. pf_ready returns in that same cycle.
- boundary_next[c] is registered alongside pkt_valid[c] and has the same latency.

## Test plan
- **Fill and single stream:** write mem[a]=a for 0..1023; cfg ch0 delay=0x019 dest=0x08; run → pkt_out ch0 = {0x08, 0x019}, {0x08, 0x01A}, …, first packet 2 cycles after run.
- **Wrap and boundary:**
  - Stimulus: ch1 delay=0x3FE, dest=0x11, run.
  - Packets: 0x3FE, 0x3FF, 0x000.
  - boundary_next[1] is high only with the 0x3FF packet.
- **Retarget and stop:**
  - While ch0 is RUN at 0x100, cfg ch0 delay=0x200 dest=0x22. The next packet is {0x22, 0x200}.
  - stop → pkt_valid=0 one cycle later.
  - stop together with run → channels stay IDLE.
- **Prefetch with backpressure:**
  - Request start=0x36, stop=0x50, dest=0x6F.
  - pf_pkt_ready toggles 1/0 → exactly 27 accepted packets, 0x36..0x50 in order, with no duplicates.
  - pf_done on the 0x50 accept; pf_ready high again afterwards.
- **Prefetch wrap and concurrency:** prefetch start=0x3FD, stop=0x002 → 6 packets 0x3FD..0x002, while ch0/ch1 stream uninterrupted. A pf_valid issued during PF_RUN is not accepted.
- **Reset and write collision:**
  - Assert reset_n=0 mid-window → all outputs clear asynchronously and pf_ready=1.
  - Write mem[0x019]=0xABCD in the same cycle ch0 reads 0x019 → the packet carries the old value; the next lap carries 0xABCD.

Source files
------------

// File: rtl/local_controller_multichannel.sv
// Circular sample buffer streamed to N_CH delay channels,
// plus a backpressured prefetch engine for arbitrary address windows.
module local_controller_multichannel #(
    parameter int N_SAMPLE          = 1024,
    parameter int DATAWIDTH         = 16,
    parameter int ADDR_VEC_WIDTH    = 8,
    parameter int SAMPLE_ADDR_WIDTH = 10,
    parameter int N_CH              = 2,
    parameter int CH_W              = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int PACKET_WIDTH      = 2*DATAWIDTH + ADDR_VEC_WIDTH
) (
    input  logic                           CLK,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [SAMPLE_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [2*DATAWIDTH-1:0]         wr_data,
    input  logic                           cfg_valid,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [SAMPLE_ADDR_WIDTH-1:0]   cfg_delay,
    input  logic [ADDR_VEC_WIDTH-1:0]      cfg_dest,
    input  logic                           run,
    input  logic                           stop,
    output logic [N_CH*PACKET_WIDTH-1:0]   pkt_out,
    output logic [N_CH-1:0]                pkt_valid,
    output logic [N_CH-1:0]                boundary_next,
    input  logic                           pf_valid,
    output logic                           pf_ready,
    input  logic [SAMPLE_ADDR_WIDTH-1:0]   pf_start,
    input  logic [SAMPLE_ADDR_WIDTH-1:0]   pf_stop,
    input  logic [ADDR_VEC_WIDTH-1:0]      pf_dest,
    output logic [PACKET_WIDTH-1:0]        pf_pkt_out,
    output logic                           pf_pkt_valid,
    input  logic                           pf_pkt_ready,
    output logic                           pf_done
);

    localparam int AW = SAMPLE_ADDR_WIDTH;
    localparam int DW = ADDR_VEC_WIDTH;
    localparam int SW = 2*DATAWIDTH;
    localparam logic [AW-1:0] LAST = AW'(N_SAMPLE-1);

    typedef enum logic [1:0] {CH_IDLE, CH_ARMED, CH_RUN} ch_state_e;
    typedef enum logic {PF_IDLE, PF_RUN} pf_state_e;

    logic [SW-1:0] mem [N_SAMPLE];

    ch_state_e       ch_state [N_CH];
    ch_state_e       ch_next  [N_CH];
    logic [AW-1:0]   ptr      [N_CH];
    logic [DW-1:0]   dest     [N_CH];
    logic [N_CH-1:0] cfg_hit;
    logic [N_CH-1:0] ch_fire;

    pf_state_e       pf_state, pf_next;
    logic [AW-1:0]   pf_ptr;
    logic [DW-1:0]   pf_dest_r;
    logic [AW:0]     pf_rem;
    logic            pf_accept, pf_load, pf_last;

    // No reset: reads see pre-write data on a same-cycle collision.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            cfg_hit[c] = cfg_valid && (cfg_ch == CH_W'(c));
            ch_next[c] = ch_state[c];
            if (stop) begin
                ch_next[c] = CH_IDLE;
            end else if (ch_state[c] != CH_RUN) begin
                if (run && (cfg_hit[c] || ch_state[c] == CH_ARMED))
                    ch_next[c] = CH_RUN;
                else if (cfg_hit[c])
                    ch_next[c] = CH_ARMED;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ch_fire[c] = (ch_state[c] == CH_RUN);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                ch_state[c] <= CH_IDLE;
                ptr[c]      <= '0;
                dest[c]     <= '0;
            end
            pkt_out       <= '0;
            pkt_valid     <= '0;
            boundary_next <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                ch_state[c] <= ch_next[c];
                if (cfg_hit[c]) begin
                    ptr[c]  <= cfg_delay;
                    dest[c] <= cfg_dest;
                end else if (ch_fire[c]) begin
                    ptr[c] <= ptr[c] + AW'(1);
                end
                pkt_valid[c]     <= ch_fire[c];
                boundary_next[c] <= ch_fire[c] && (ptr[c] == LAST);
                if (ch_fire[c])
                    pkt_out[c*PACKET_WIDTH +: PACKET_WIDTH] <=
                        {dest[c], mem[ptr[c]]};
            end
        end
    end

    always_comb begin
        pf_ready  = (pf_state == PF_IDLE);
        pf_accept = pf_valid && pf_ready;
        pf_load   = (pf_state == PF_RUN) && (pf_rem != '0) &&
                    (!pf_pkt_valid || pf_pkt_ready);
        pf_last   = (pf_state == PF_RUN) && (pf_rem == '0) &&
                    pf_pkt_valid && pf_pkt_ready;
    end

    always_comb begin
        pf_next = pf_state;
        unique case (pf_state)
            PF_IDLE: if (pf_accept) pf_next = PF_RUN;
            PF_RUN:  if (pf_last)   pf_next = PF_IDLE;
            default: pf_next = PF_IDLE;
        endcase
    end

    // pf_rem counts addresses not yet loaded into the output register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pf_state     <= PF_IDLE;
            pf_ptr       <= '0;
            pf_dest_r    <= '0;
            pf_rem       <= '0;
            pf_pkt_out   <= '0;
            pf_pkt_valid <= 1'b0;
            pf_done      <= 1'b0;
        end else begin
            pf_state <= pf_next;
            pf_done  <= pf_last;
            if (pf_accept) begin
                pf_ptr    <= pf_start;
                pf_dest_r <= pf_dest;
                pf_rem    <= {1'b0, AW'(pf_stop - pf_start)} + (AW+1)'(1);
            end else if (pf_load) begin
                pf_ptr <= pf_ptr + AW'(1);
                pf_rem <= pf_rem - (AW+1)'(1);
            end
            if (pf_load) begin
                pf_pkt_out   <= {pf_dest_r, mem[pf_ptr]};
                pf_pkt_valid <= 1'b1;
            end else if (pf_pkt_ready) begin
                pf_pkt_valid <= 1'b0;
            end
        end
    end

endmodule
